bit_serializer: RTL and testbench
=================================

# bit_serializer

Parallel-to-serial front end for the bit-stream pattern detectors in the lab designs. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on `x`, with `x_valid` qualifying each bit. A one-word holding buffer lets back-to-back words come out as a gapless stream. Overlapping patterns that span a word boundary are therefore seen intact by the downstream detector, whose `x` input is driven directly by this block.

## Interface
- WIDTH, 8, word width in bits; must be ≥ 2.
- MSB_FIRST, 1, 1 = emit bit WIDTH-1 first; 0 = emit bit 0 first.

- clk  input  1  clock, rising-edge.
- rst_b  input  1  reset, asynchronous, active-low.
- din  input  WIDTH  word to serialize.
- din_valid  input  1  din holds a word.
- din_ready  output  1  block can take a word; equals !hb_full.
- x  output  1  current serial bit; 0 when x_valid = 0.
- x_valid  output  1  x carries a real bit this cycle (state SHIFT).
- last  output  1  x is the final bit of the current word.
- busy  output  1  state SHIFT or hb_full.

## Operation
- Internal state:
  - state ∈ {IDLE, SHIFT}.
  - Shift register sr[WIDTH-1:0].
  - Bit counter cnt, $clog2(WIDTH) bits.
  - Holding buffer hb[WIDTH-1:0] with flag hb_full.
- A word is accepted on a rising edge where din_valid = 1 and din_ready = 1. din_valid while din_ready = 0 is ignored; the word is not lost, because the source holds it.
- x = sr[WIDTH-1] when MSB_FIRST = 1, otherwise sr[0]; gated by x_valid.
- last = (state == SHIFT) && (cnt == WIDTH-1).
- IDLE:
  - On accept: sr ← din, cnt ← 0, go to SHIFT. The holding buffer is bypassed.
  - Otherwise remain in IDLE. hb_full is always 0 in IDLE.
- SHIFT, not last:
  - sr shifts toward the output end and zero-fills; cnt ← cnt+1.
  - On accept: hb ← din, hb_full ← 1.
- SHIFT, last, resolved in priority order:
  - hb_full = 1: sr ← hb, cnt ← 0, stay in SHIFT. hb_full ← 0, unless a word is accepted on the same edge.
  - Accept on the same edge is only possible when hb_full = 0, since din_ready = !hb_full. In that case sr ← din, cnt ← 0, stay in SHIFT.
  - Neither: go to IDLE; sr and cnt are don't-care but held.
- At most one word is accepted per clock. Capacity is one word shifting plus one buffered.
- Reset (asynchronous assert, any time):
  - state ← IDLE, sr ← 0, cnt ← 0, hb ← 0, hb_full ← 0.
  - The word in flight and the buffered word are discarded, with no partial bits after release.

## Timing
- Reset values:
  - x = 0, x_valid = 0, last = 0, busy = 0.
  - din_ready = 1, but no accept is registered while rst_b = 0.
- Latency: a word accepted at edge E0 drives its first bit in the cycle following E0. Bit k is valid between edges E0+k and E0+k+1; last is high between E0+WIDTH-1 and E0+WIDTH.
- Gapless streaming: the next word must be accepted at or before edge E0+WIDTH, either into hb earlier or directly on that edge. If it is, x_valid stays 1 continuously.
- Throughput: one bit per clock, i.e. one word per WIDTH clocks.
- din_ready drops the cycle after a buffer write and rises the cycle after the hb→sr transfer.
- All outputs are decoded from registers; there is no combinational path from din or din_valid to any output.

## Test plan
Unless stated otherwise, WIDTH = 8 and MSB_FIRST = 1.
- **Single word:** reset, then accept 8'hB6.
  - x must be 1,0,1,1,0,1,1,0 with x_valid = 1 for exactly 8 cycles.
  - last must be high on the 8th bit only; then IDLE with x = 0.
- **Back-to-back:** accept 8'hB6 and, one cycle later, 8'h6D (goes into hb).
  - 16 consecutive valid bits, 1011011001101101, with no x_valid gap.
  - din_ready low from the cycle after the second accept until the cycle after the first word's last bit.
- **Back-pressure:** hold din_valid = 1 with three distinct words while in SHIFT with hb_full.
  - No accept while din_ready = 0.
  - All three words appear in order, with no loss or duplication.
- **Direct load on the last edge:** present a word exactly at edge E0+8 with hb empty.
  - That word's first bit is output on the next cycle, with no gap and no pass through hb.
- **Reset mid-word:** assert rst_b low after 3 bits of 8'hFF while hb_full.
  - Outputs take their reset values immediately; after release no stale bits appear and din_ready = 1.
- **LSB first:** set MSB_FIRST = 0 and accept 8'hB6.
  - x must be 0,1,1,0,1,1,0,1.

Source files
------------

// File: rtl/bit_serializer.sv
//------------------------------------------------------------------------------
// Module   : bit_serializer
// Purpose  : Parallel-to-serial front end. Takes WIDTH-bit words over a
//            valid/ready handshake and emits them one bit per clock on x.
//            A one-word holding buffer lets consecutive words stream with
//            no gap in x_valid.
// Revision : 1.0  initial release
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_b      in   1      asynchronous active-low reset
//   din        in   WIDTH  word to serialize
//   din_valid  in   1      din holds a word
//   din_ready  out  1      block can take a word (holding buffer empty)
//   x          out  1      current serial bit, 0 when x_valid is low
//   x_valid    out  1      x carries a real bit this cycle
//   last       out  1      x is the final bit of the current word
//   busy       out  1      shifting or a word is buffered
//------------------------------------------------------------------------------
`default_nettype none

module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_sr_nxt;
  logic [WIDTH-1:0] r_hb;
  logic [WIDTH-1:0] w_hb_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             r_hb_full;
  logic             w_hb_full_nxt;

  logic             w_accept;
  logic             w_last;
  logic             w_out_bit;
  logic [WIDTH-1:0] w_sr_shifted;

  // The buffer is the only thing that can refuse a word: in IDLE it is
  // always empty, and on the last bit with it empty a word loads directly.
  assign w_accept = din_valid & ~r_hb_full;
  assign w_last   = (r_state == S_SHIFT) && (r_cnt == CW'(WIDTH - 1));

  // Output end of the shift register and the zero-filling shift toward it.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_out_bit    = r_sr[WIDTH-1];
      assign w_sr_shifted = {r_sr[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_out_bit    = r_sr[0];
      assign w_sr_shifted = {1'b0, r_sr[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state   <= S_IDLE;
      r_sr      <= '0;
      r_cnt     <= '0;
      r_hb      <= '0;
      r_hb_full <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sr      <= w_sr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_hb      <= w_hb_nxt;
      r_hb_full <= w_hb_full_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_sr_nxt      = r_sr;
    w_cnt_nxt     = r_cnt;
    w_hb_nxt      = r_hb;
    w_hb_full_nxt = r_hb_full;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_sr_nxt    = din;
          w_cnt_nxt   = '0;
          w_state_nxt = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (!w_last) begin
          w_sr_nxt  = w_sr_shifted;
          w_cnt_nxt = r_cnt + CW'(1);
          if (w_accept) begin
            w_hb_nxt      = din;
            w_hb_full_nxt = 1'b1;
          end
        end else if (r_hb_full) begin
          // Buffered word takes over; no accept is possible this edge
          // because din_ready is low while the buffer is full.
          w_sr_nxt      = r_hb;
          w_cnt_nxt     = '0;
          w_hb_full_nxt = 1'b0;
        end else if (w_accept) begin
          // Direct load on the final edge keeps the stream gapless.
          w_sr_nxt  = din;
          w_cnt_nxt = '0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign x_valid   = (r_state == S_SHIFT);
  assign x         = x_valid & w_out_bit;
  assign last      = w_last;
  assign busy      = x_valid | r_hb_full;
  assign din_ready = ~r_hb_full;

endmodule

`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none

module tb_bit_serializer;

  localparam int W = 8;

  logic         clk;
  logic         rst_b;
  logic [W-1:0] din_m, din_l;
  logic         vld_m, vld_l;
  logic         rdy_m, rdy_l;
  logic         x_m, x_l;
  logic         xv_m, xv_l;
  logic         last_m, last_l;
  logic         busy_m, busy_l;

  int n_pass = 0;
  int n_tot  = 0;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_b(rst_b), .din(din_m), .din_valid(vld_m),
    .din_ready(rdy_m), .x(x_m), .x_valid(xv_m), .last(last_m), .busy(busy_m)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_b(rst_b), .din(din_l), .din_valid(vld_l),
    .din_ready(rdy_l), .x(x_l), .x_valid(xv_l), .last(last_l), .busy(busy_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: the block holds up to two whole words; the oldest one
  // is being emitted and k bits of it have already gone out.
  typedef struct {
    int           n;
    logic [W-1:0] w0;
    logic [W-1:0] w1;
    int           k;
  } model_t;

  function automatic model_t step(input model_t m, input logic v, input logic [W-1:0] d);
    model_t r;
    bit     can_take;
    r = m;
    can_take = (m.n < 2);
    if (r.n > 0) begin
      r.k++;
      if (r.k == W) begin
        r.w0 = r.w1;
        r.n--;
        r.k = 0;
      end
    end
    if (v && can_take) begin
      if (r.n == 0) begin
        r.w0 = d;
        r.k  = 0;
      end else begin
        r.w1 = d;
      end
      r.n++;
    end
    return r;
  endfunction

  function automatic logic exp_x(input model_t m, input bit msb);
    if (m.n == 0) return 1'b0;
    return msb ? m.w0[W-1-m.k] : m.w0[m.k];
  endfunction

  model_t mm, ml, mzero;
  initial begin
    mzero.n = 0; mzero.w0 = '0; mzero.w1 = '0; mzero.k = 0;
  end

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mm <= mzero;
      ml <= mzero;
    end else begin
      mm <= step(mm, vld_m, din_m);
      ml <= step(ml, vld_l, din_l);
    end
  end

  bit started = 1'b0;

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("m_x",      x_m,    exp_x(mm, 1'b1));
      chk("m_xvalid", xv_m,   mm.n > 0);
      chk("m_last",   last_m, (mm.n > 0) && (mm.k == W-1));
      chk("m_busy",   busy_m, mm.n > 0);
      chk("m_ready",  rdy_m,  mm.n < 2);
      chk("l_x",      x_l,    exp_x(ml, 1'b0));
      chk("l_xvalid", xv_l,   ml.n > 0);
      chk("l_last",   last_l, (ml.n > 0) && (ml.k == W-1));
      chk("l_ready",  rdy_l,  ml.n < 2);
    end
  end

  // Log of emitted bits for the hand-computed stream checks.
  logic [63:0] log_m, log_l;
  int          nlog_m, nlog_l, nlast_m;
  always @(negedge clk) begin
    if (xv_m) begin
      log_m = {log_m[62:0], x_m};
      nlog_m++;
      if (last_m) nlast_m++;
    end
    if (xv_l) begin
      log_l = {log_l[62:0], x_l};
      nlog_l++;
    end
  end

  task automatic clear_log();
    log_m = '0; log_l = '0; nlog_m = 0; nlog_l = 0; nlast_m = 0;
  endtask

  // Present a word and hold it until the handshake completes; returns at the
  // negedge following the accepting edge.
  task automatic send(input bit sel, input logic [W-1:0] d);
    bit rdy;
    bit acc;
    acc = 1'b0;
    if (sel) begin din_l = d; vld_l = 1'b1; end
    else     begin din_m = d; vld_m = 1'b1; end
    for (int t = 0; t < 100; t++) begin
      rdy = sel ? rdy_l : rdy_m;
      @(posedge clk);
      @(negedge clk);
      if (rdy) begin
        acc = 1'b1;
        break;
      end
    end
    chk("send_accept", acc, 1'b1);
    if (sel) vld_l = 1'b0;
    else     vld_m = 1'b0;
  endtask

  initial begin
    rst_b = 1'b0;
    din_m = '0; din_l = '0; vld_m = 1'b0; vld_l = 1'b0;
    clear_log();
    repeat (3) @(negedge clk);
    chk("rst_x",      x_m,    1'b0);
    chk("rst_xvalid", xv_m,   1'b0);
    chk("rst_last",   last_m, 1'b0);
    chk("rst_busy",   busy_m, 1'b0);
    chk("rst_ready",  rdy_m,  1'b1);
    started = 1'b1;
    #2 rst_b = 1'b1;
    @(negedge clk);

    // Single word
    clear_log();
    send(1'b0, 8'hB6);
    repeat (10) @(negedge clk);
    chk("single_bits",  log_m[7:0], 8'hB6);
    chk("single_count", nlog_m, 8);
    chk("single_last",  nlast_m, 1);
    chk("single_idle",  xv_m, 1'b0);

    // Back-to-back
    clear_log();
    send(1'b0, 8'hB6);
    send(1'b0, 8'h6D);
    chk("b2b_ready_low", rdy_m, 1'b0);
    repeat (18) @(negedge clk);
    chk("b2b_bits",  log_m[15:0], 16'hB66D);
    chk("b2b_count", nlog_m, 16);
    chk("b2b_last",  nlast_m, 2);

    // Back-pressure: third and fourth words wait while the buffer is full
    clear_log();
    send(1'b0, 8'hA1);
    send(1'b0, 8'hC3);
    send(1'b0, 8'h3C);
    send(1'b0, 8'h5A);
    repeat (34) @(negedge clk);
    chk("bp_bits",  log_m[31:0], 32'hA1C33C5A);
    chk("bp_count", nlog_m, 32);

    // Direct load exactly on the last edge
    clear_log();
    send(1'b0, 8'h96);
    repeat (7) @(negedge clk);
    send(1'b0, 8'h0F);
    chk("direct_ready", rdy_m, 1'b1);
    repeat (12) @(negedge clk);
    chk("direct_bits",  log_m[15:0], 16'h960F);
    chk("direct_count", nlog_m, 16);

    // Reset mid-word with the buffer full
    clear_log();
    send(1'b0, 8'hFF);
    send(1'b0, 8'h5A);
    @(negedge clk);
    #2 rst_b = 1'b0;
    #1;
    chk("mid_rst_x",      x_m,    1'b0);
    chk("mid_rst_xvalid", xv_m,   1'b0);
    chk("mid_rst_last",   last_m, 1'b0);
    chk("mid_rst_busy",   busy_m, 1'b0);
    chk("mid_rst_ready",  rdy_m,  1'b1);
    @(negedge clk);
    #2 rst_b = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_rst_count", nlog_m, 3);
    chk("post_rst_bits",  log_m[2:0], 3'b111);
    chk("post_rst_ready", rdy_m, 1'b1);

    // LSB first
    clear_log();
    send(1'b1, 8'hB6);
    repeat (10) @(negedge clk);
    chk("lsb_bits",  log_l[7:0], 8'h6D);
    chk("lsb_count", nlog_l, 8);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

`default_nettype wire
